// File: rtl/fp_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_seq_pkg
// Shared single-precision constants and the multiplier FSM state type.
// Imported by fp_mul_seq (top) and fp_mul_special (special-case classifier).
// -----------------------------------------------------------------------------
package fp_mul_seq_pkg;

  localparam int          FP_BIAS     = 127;
  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam int          FP_MANT_W   = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : fp_mul_seq_pkg

// File: rtl/fp_mul_special.sv
// -----------------------------------------------------------------------------
// fp_mul_special
// Purely combinational classifier for operand pairs whose product does not
// need the shift-add datapath.
// Ports:
//   a, b          : fp32 operands
//   out           : special result (valid only when check_special = 1)
//   check_special : operands form a special case
// Priority: NaN or 0*inf -> quiet NaN, then infinity, then zero. Any operand
// with a zero exponent (zero or denormal) is treated as zero.
// -----------------------------------------------------------------------------
module fp_mul_special
  import fp_mul_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        check_special
);

  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign_r;

  assign exp_a  = a[30:FP_MANT_W];
  assign exp_b  = b[30:FP_MANT_W];
  assign frac_a = a[FP_MANT_W-1:0];
  assign frac_b = b[FP_MANT_W-1:0];
  assign sign_r = a[31] ^ b[31];

  assign nan_a  = (exp_a == FP_EXP_ONES) && (frac_a != '0);
  assign nan_b  = (exp_b == FP_EXP_ONES) && (frac_b != '0);
  assign inf_a  = (exp_a == FP_EXP_ONES) && (frac_a == '0);
  assign inf_b  = (exp_b == FP_EXP_ONES) && (frac_b == '0);
  assign zero_a = (exp_a == 8'd0);
  assign zero_b = (exp_b == 8'd0);

  always_comb begin
    out           = 32'd0;
    check_special = 1'b1;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      out = FP_QNAN;
    end else if (inf_a || inf_b) begin
      out = {sign_r, FP_EXP_ONES, 23'd0};
    end else if (zero_a || zero_b) begin
      out = {sign_r, 31'd0};
    end else begin
      check_special = 1'b0;
    end
  end

endmodule : fp_mul_special

// File: rtl/fp_mul_seq.sv
// -----------------------------------------------------------------------------
// fp_mul_seq
// Sequential fp32 multiplier: 24-cycle shift-add mantissa multiply, one
// normalisation cycle, truncating rounding, denormals flushed to zero.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in1, in2            : operands, sampled when in_valid && in_ready
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   out                 : registered product
//   out_valid/out_ready : result handshake (valid only in DONE)
// -----------------------------------------------------------------------------
module fp_mul_seq
  import fp_mul_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic signed [9:0] BIAS_S    = 10'(FP_BIAS);
  localparam logic signed [9:0] BIAS_M1_S = 10'(FP_BIAS - 1);

  state_t                  state_q;
  logic                    sign_q;
  logic [7:0]              ea_q, eb_q;
  logic [23:0]             ma_q, mb_q;
  logic [47:0]             acc_q;
  logic [4:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   out_q;

  logic [47:0]             partial_d;
  logic [47:0]             acc_d;
  logic signed [9:0]       exp_d;
  logic [22:0]             frac_d;
  logic [31:0]             norm_d;

  logic [31:0]             spec_out;
  logic                    spec_hit;

  fp_mul_special u_special (
    .a             (in1),
    .b             (in2),
    .out           (spec_out),
    .check_special (spec_hit)
  );

  // Shift-add step: multiplier bit cnt_q selects the multiplicand shifted
  // into place; the product builds up LSB first over 24 cycles.
  always_comb begin
    partial_d = 48'd0;
    if (mb_q[cnt_q]) begin
      partial_d = {24'd0, ma_q} << cnt_q;
    end
    acc_d = acc_q + partial_d;
  end

  // Normalisation: the product of two 1.x mantissas lies in [1,4), so at
  // most one position of adjustment; lower bits are truncated.
  always_comb begin
    if (acc_q[47]) begin
      frac_d = acc_q[46:24];
      exp_d  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_M1_S;
    end else begin
      frac_d = acc_q[45:23];
      exp_d  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_S;
    end
    if (exp_d >= 10'sd255) begin
      norm_d = {sign_q, FP_EXP_ONES, 23'd0};
    end else if (exp_d <= 10'sd0) begin
      norm_d = {sign_q, 31'd0};
    end else begin
      norm_d = {sign_q, exp_d[7:0], frac_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      ma_q    <= 24'd0;
      mb_q    <= 24'd0;
      acc_q   <= 48'd0;
      cnt_q   <= 5'd0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in1[31] ^ in2[31];
            ea_q   <= in1[30:FP_MANT_W];
            eb_q   <= in2[30:FP_MANT_W];
            ma_q   <= {1'b1, in1[FP_MANT_W-1:0]};
            mb_q   <= {1'b1, in2[FP_MANT_W-1:0]};
            acc_q  <= 48'd0;
            cnt_q  <= 5'd0;
            if (spec_hit) begin
              out_q   <= spec_out;
              state_q <= DONE;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          out_q   <= norm_d;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags decode the state register only, so no input reaches
  // any output combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule : fp_mul_seq
